relu_backward_sequencer: RTL and testbench

Tile sequencer for the ReLU backward datapath (`relu_backward_layer`). It streams `num_tiles` vectors of `LANES` 32-bit floats from a fixed-latency read port through the datapath and writes the results in order to a destination region. A credit-limited output FIFO absorbs write-side backpressure. It sits between the layer-level control (start/done) and the local tensor memory.

---
 rtl/relu_backward_sequencer_pkg.sv | 16 +
 rtl/relu_backward_sequencer_if.sv | 38 +++
 rtl/relu_backward_sequencer_out_fifo.sv | 75 +++++++
 rtl/relu_backward_sequencer.sv | 142 ++++++++++++++
 tb/tb_relu_backward_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/relu_backward_sequencer_pkg.sv
// Shared types for the ReLU backward tile sequencer: float word type and
// sequencer state encoding.
package relu_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } relu_seq_state_e;

endpackage

// File: rtl/relu_backward_sequencer_if.sv
// Memory-read / datapath / write-sink bundle between the tile sequencer
// (master) and the local tensor memory plus ReLU backward datapath (slave).
interface relu_backward_sequencer_if
    import relu_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int ADDR_W = 16
) ();

    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    fp32_t [LANES-1:0]      dp_out_vec;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    fp32_t [LANES-1:0]      wr_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  dp_out_vec,
        output wr_valid,
        input  wr_ready,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output dp_out_vec,
        input  wr_valid,
        output wr_ready,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/relu_backward_sequencer_out_fifo.sv
// Output FIFO with a registered head word: the head sits in its own flop and
// the remaining DEPTH-1 entries live in a circular buffer behind it.
module relu_bwd_out_fifo #(
    parameter int  DEPTH = 5,
    parameter int  DW    = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DW-1:0]    din,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [DW-1:0]    head
);

    localparam int SD    = DEPTH - 1;
    localparam int PTR_W = (SD > 1) ? $clog2(SD) : 1;

    logic [DW-1:0]    mem [SD];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;
    logic             head_from_mem;
    logic             head_from_din;
    logic             mem_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SD - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push bypasses the buffer whenever the head slot is (or is becoming) free.
    always_comb begin
        full          = (count == CNT_W'(DEPTH));
        pop_ok        = pop && (count != '0);
        push_ok       = push && (!full || pop_ok);
        head_from_mem = pop_ok && (count > CNT_W'(1));
        head_from_din = push_ok && ((count == '0) || (pop_ok && (count == CNT_W'(1))));
        mem_wr        = push_ok && !head_from_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            head   <= '0;
        end else begin
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (head_from_mem) begin
                head   <= mem[rd_ptr];
                rd_ptr <= ptr_inc(rd_ptr);
            end else if (head_from_din) begin
                head <= din;
            end
            if (mem_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers
    // define which entries are live, so clearing data would only cost flops.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: rtl/relu_backward_sequencer.sv
// Tile sequencer: streams num_tiles vectors from memory through the ReLU
// backward datapath into a credit-limited output FIFO and an in-order writer.
module relu_backward_sequencer
    import relu_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int DP_LAT     = 1,
    parameter int FIFO_DEPTH = MEM_LAT + DP_LAT + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_src,
    input  logic [ADDR_W-1:0]         base_dst,
    input  logic [ADDR_W-1:0]         num_tiles,
    output logic                      busy,
    output logic                      done,
    relu_backward_sequencer_if.master bus
);

    localparam int PIPE_LAT = MEM_LAT + DP_LAT;
    localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W   = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
    localparam int DW       = LANES * FP_W;

    relu_seq_state_e     state_q;
    relu_seq_state_e     state_d;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   num_q;
    logic [ADDR_W-1:0]   issued_q;
    logic [ADDR_W-1:0]   written_q;
    logic [PIPE_LAT-1:0] vpipe_q;
    logic [CRED_W-1:0]   inflight;
    logic [FCNT_W-1:0]   fifo_count;
    logic [DW-1:0]       fifo_head;
    logic                rd_en;
    logic                push;
    logic                pop;
    logic                credit_ok;
    logic                last_read;
    logic                last_write;
    logic                accept_start;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + CRED_W'(vpipe_q[i]);
        end
    end

    // Reserving a FIFO slot for every read still in flight means a push can
    // never find the FIFO full, whatever the write side does.
    assign credit_ok    = (CRED_W'(fifo_count) + inflight) < CRED_W'(FIFO_DEPTH);
    assign push         = vpipe_q[PIPE_LAT-1];
    assign pop          = bus.wr_valid && bus.wr_ready;
    assign last_read    = (issued_q == num_q - ADDR_W'(1));
    assign last_write   = pop && (written_q == num_q - ADDR_W'(1));
    assign accept_start = (state_q == S_IDLE) && start;

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path can leave a variable unassigned and infer a latch.
        state_d = state_q;
        rd_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_tiles == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                rd_en = (issued_q < num_q) && credit_ok;
                if (rd_en && last_read) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_write) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            num_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            vpipe_q   <= '0;
        end else begin
            state_q <= state_d;
            vpipe_q <= (vpipe_q << 1) | PIPE_LAT'(rd_en);
            if (accept_start) begin
                src_q     <= base_src;
                dst_q     <= base_dst;
                num_q     <= num_tiles;
                issued_q  <= '0;
                written_q <= '0;
            end else begin
                if (rd_en) begin
                    issued_q <= issued_q + ADDR_W'(1);
                end
                if (pop) begin
                    written_q <= written_q + ADDR_W'(1);
                end
            end
        end
    end

    relu_bwd_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .din   (bus.dp_out_vec),
        .pop   (pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = src_q + issued_q;
    assign bus.wr_valid = (fifo_count != '0);
    assign bus.wr_addr  = dst_q + written_q;
    assign bus.wr_data  = fifo_head;

endmodule

// File: tb/tb_relu_backward_sequencer.sv
// Directed bench for relu_backward_sequencer with a MEM_LAT=2 memory whose
// location a holds a in every lane, and an identity DP_LAT=1 datapath stub.
module tb_relu_backward_sequencer;
    import relu_pkg::*;

    localparam int LANES  = 16;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_src;
    logic [ADDR_W-1:0] base_dst;
    logic [ADDR_W-1:0] num_tiles;
    logic              busy;
    logic              done;

    relu_backward_sequencer_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    relu_backward_sequencer #(
        .LANES   (LANES),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (2),
        .DP_LAT  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_src  (base_src),
        .base_dst  (base_dst),
        .num_tiles (num_tiles),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Memory + datapath model; the read address is captured mid-cycle.
    logic [ADDR_W-1:0] addr_seen;
    fp32_t [LANES-1:0] rd_stage1;
    fp32_t [LANES-1:0] rd_data;

    always @(negedge clk) addr_seen = bus.rd_addr;

    always @(posedge clk) begin
        rd_stage1      <= {LANES{32'(addr_seen)}};
        rd_data        <= rd_stage1;
        bus.dp_out_vec <= rd_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int                rd_cyc[$];
    logic [ADDR_W-1:0] rd_adr[$];
    int                wr_cyc[$];
    logic [ADDR_W-1:0] wr_adr[$];
    logic [31:0]       wr_lo[$];
    logic [31:0]       wr_hi[$];
    int                done_cyc[$];
    int                busy_cycles;
    int                peek_count;

    // Entered #1 after a rising edge with the DUT idle; that edge-to-be is cycle 0.
    task automatic run_job(input logic [ADDR_W-1:0] n, input logic [ADDR_W-1:0] src,
                           input logic [ADDR_W-1:0] dst, input int ready_from,
                           input int restart_at, input int peek_at, input int max_cyc);
        rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
        wr_lo.delete(); wr_hi.delete(); done_cyc.delete();
        busy_cycles = 0;
        peek_count  = -1;
        base_src  = src;
        base_dst  = dst;
        num_tiles = n;
        start     = 1'b1;
        bus.wr_ready = (ready_from <= 0);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            bus.wr_ready = (cyc >= ready_from);
            if (cyc == restart_at) begin
                start     = 1'b1;
                base_src  = 16'h0555;
                base_dst  = 16'h0AAA;
                num_tiles = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (bus.rd_en) begin
                rd_cyc.push_back(cyc);
                rd_adr.push_back(bus.rd_addr);
            end
            if (bus.wr_valid && bus.wr_ready) begin
                wr_cyc.push_back(cyc);
                wr_adr.push_back(bus.wr_addr);
                wr_lo.push_back(bus.wr_data[0]);
                wr_hi.push_back(bus.wr_data[LANES-1]);
            end
            if (done) done_cyc.push_back(cyc);
            if (busy) busy_cycles++;
            if (cyc == peek_at) peek_count = int'(dut.fifo_count);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Reads from rd0 and writes to wr0 in order, data equal to the read address.
    // A negative start cycle skips the cycle checks for that side.
    task automatic check_stream(input string tag, input int n,
                                input logic [ADDR_W-1:0] rd0, input int rd_c0,
                                input logic [ADDR_W-1:0] wr0, input int wr_c0);
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] ew;
        check({tag, "_nrd"}, 64'(rd_adr.size()), 64'(n));
        check({tag, "_nwr"}, 64'(wr_adr.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            ea = rd0 + ADDR_W'(i);
            ew = wr0 + ADDR_W'(i);
            if (i < rd_adr.size()) begin
                check($sformatf("%s_rd_addr%0d", tag, i), 64'(rd_adr[i]), 64'(ea));
                if (rd_c0 >= 0) check($sformatf("%s_rd_cyc%0d", tag, i), 64'(rd_cyc[i]), 64'(rd_c0 + i));
            end
            if (i < wr_adr.size()) begin
                check($sformatf("%s_wr_addr%0d", tag, i), 64'(wr_adr[i]), 64'(ew));
                check($sformatf("%s_wr_lane0_%0d", tag, i), 64'(wr_lo[i]), 64'(ea));
                check($sformatf("%s_wr_lane15_%0d", tag, i), 64'(wr_hi[i]), 64'(ea));
                if (wr_c0 >= 0) check($sformatf("%s_wr_cyc%0d", tag, i), 64'(wr_cyc[i]), 64'(wr_c0 + i));
            end
        end
    endtask

    task automatic check_done(input string tag, input int exp_cyc);
        check({tag, "_ndone"}, 64'(done_cyc.size()), 64'd1);
        check({tag, "_done_cyc"}, (done_cyc.size() > 0) ? 64'(done_cyc[0]) : '1, 64'(exp_cyc));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     64'(busy),         64'd0);
        check({tag, "_done"},     64'(done),         64'd0);
        check({tag, "_rd_en"},    64'(bus.rd_en),    64'd0);
        check({tag, "_rd_addr"},  64'(bus.rd_addr),  64'd0);
        check({tag, "_wr_valid"}, 64'(bus.wr_valid), 64'd0);
        check({tag, "_wr_addr"},  64'(bus.wr_addr),  64'd0);
        check({tag, "_wr_data"},  64'(bus.wr_data == '0), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        reset        = 1'b0;
        start        = 1'b0;
        base_src     = '0;
        base_dst     = '0;
        num_tiles    = '0;
        bus.wr_ready = 1'b0;
        #12;
        check_outputs_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: basic 4-tile job with an always-ready sink
        run_job(16'd4, 16'h0010, 16'h0080, 0, 0, 0, 12);
        check_stream("t1", 4, 16'h0010, 1, 16'h0080, 5);
        check_done("t1", 9);
        check("t1_busy_cycles", 64'(busy_cycles), 64'd9);

        // 2: zero-length job
        run_job(16'd0, 16'h0010, 16'h0080, 0, 0, 0, 4);
        check_stream("t2", 0, 16'h0010, 1, 16'h0080, 5);
        check_done("t2", 1);
        check("t2_busy_cycles", 64'(busy_cycles), 64'd1);

        // 3: sink stalled until cycle 20; credits cap reads at the FIFO depth
        run_job(16'd8, 16'h0020, 16'h0040, 20, 0, 19, 32);
        held = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] < 20) held++;
        check("t3_reads_held", 64'(held), 64'd5);
        check("t3_fifo_count", 64'(peek_count), 64'd5);
        check_stream("t3", 8, 16'h0020, -1, 16'h0040, 20);
        check_done("t3", 28);

        // 4: start pulsed mid-job with other bases is ignored
        run_job(16'd4, 16'h0030, 16'h0090, 0, 3, 0, 12);
        check_stream("t4", 4, 16'h0030, 1, 16'h0090, 5);
        check_done("t4", 9);

        // 5: asynchronous reset during cycle 4 of an 8-tile job
        base_src  = 16'h0100;
        base_dst  = 16'h0200;
        num_tiles = 16'd8;
        bus.wr_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("t5_abort");
        repeat (2) begin
            @(negedge clk);
            check("t5_done_in_reset", 64'(done), 64'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_done_after_reset", 64'(done), 64'd0);
        check("t5_busy_after_reset", 64'(busy), 64'd0);
        @(posedge clk); #1;
        run_job(16'd2, 16'h0060, 16'h0070, 0, 0, 0, 10);
        check_stream("t5", 2, 16'h0060, 1, 16'h0070, 5);
        check_done("t5", 7);

        // 6: address wrap-around on both sides
        run_job(16'd4, 16'hFFFD, 16'hFFFE, 0, 0, 0, 12);
        check_stream("t6", 4, 16'hFFFD, 1, 16'hFFFE, 5);
        check_done("t6", 9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
